// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
//   Definitions shared by the APB command master, the APB GPIO slave and the
//   benches that drive them.
//
//   Contents:
//     apb_state_e      - requester FSM state encoding (IDLE, SETUP, ACCESS)
//     GPIO_*           - GPIO slave register map (word addresses on PADDR)
//     apb_strb_for()   - PSTRB value for a transfer: reads never drive strobes
// -----------------------------------------------------------------------------
package apb_pkg;

    // Requester FSM state encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // GPIO slave register map.
    localparam int unsigned GPIO_MODE      = 0;
    localparam int unsigned GPIO_DIRECTION = 1;
    localparam int unsigned GPIO_OUTPUT    = 2;
    localparam int unsigned GPIO_INPUT     = 3;

    // APB reads carry no byte lanes, so the strobes are forced low for them.
    function automatic logic [3:0] apb_strb_for(input logic       write,
                                                input logic [3:0] strb);
        return write ? strb : 4'b0000;
    endfunction

endpackage : apb_pkg

// File: rtl/apb_wdog_counter.sv
// -----------------------------------------------------------------------------
// apb_wdog_counter
//   Counts ACCESS cycles in which the slave holds PREADY low and flags the
//   cycle in which the LIMIT-th such wait is being spent, so the requester can
//   abort on that same edge. LIMIT = 0 disables the watchdog entirely.
//
//   Parameters:
//     LIMIT      - number of waiting ACCESS cycles allowed before abort
//
//   Ports:
//     clk_i      in   clock, rising edge
//     rst_i      in   synchronous active-high reset, clears the count
//     clear_i    in   restart the count (asserted when a command is accepted)
//     enable_i   in   current cycle is an ACCESS cycle with PREADY low
//     expired_o  out  this waiting cycle is the LIMIT-th one; abort now
// -----------------------------------------------------------------------------
module apb_wdog_counter #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;

    // Count value held during the final permitted waiting cycle. Only
    // meaningful when LIMIT is nonzero.
    localparam logic [CW-1:0] LAST = (LIMIT == 0) ? '0 : CW'(LIMIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The count saturates at LAST: once it gets there the requester leaves
    // ACCESS on that edge (timeout or completion), so it never needs to go
    // further.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (LIMIT != 0) && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: reset is sampled on the clock edge (synchronous), which is how
    // the surrounding APB domain is reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is only reported in a waiting cycle; a cycle where PREADY is high
    // deasserts enable_i, so a completion on the limit cycle wins.
    assign expired_o = (LIMIT != 0) && enable_i && (count_q == LAST);

endmodule : apb_wdog_counter

// File: rtl/apb_cmd_master.sv
// -----------------------------------------------------------------------------
// apb_cmd_master
//   Single-outstanding APB requester. Accepts one command at a time on a
//   valid/ready port, runs it as an APB SETUP + ACCESS transfer, waits for
//   PREADY and reports completion on a one-cycle response strobe. A watchdog
//   aborts a transfer whose slave keeps PREADY low for TIMEOUT_CYCLES ACCESS
//   cycles.
//
//   Parameters:
//     PDATA_SIZE      - APB data width, multiple of 8
//     PADDR_SIZE      - APB address width
//     TIMEOUT_CYCLES  - waiting ACCESS cycles before abort, 0 = never abort
//
//   Ports:
//     APB_CLK      in   clock, all logic on the rising edge
//     APB_RESET    in   synchronous active-high reset
//     cmd_valid    in   command request
//     cmd_ready    out  a command is accepted this cycle if cmd_valid is high
//     cmd_write    in   1 = write, 0 = read
//     cmd_addr     in   target address
//     cmd_wdata    in   write data
//     cmd_strb     in   write byte strobes
//     rsp_valid    out  one-cycle completion pulse
//     rsp_rdata    out  read data; 0 for writes and timeouts
//     rsp_error    out  PSLVERR seen or timeout; qualified by rsp_valid
//     rsp_timeout  out  completion caused by the watchdog; qualified by rsp_valid
//     APB_PSEL     out  slave select
//     APB_PENABLE  out  access phase
//     APB_PADDR    out  address
//     APB_PWRITE   out  direction
//     APB_PSTRB    out  byte strobes (0 for reads)
//     APB_PWDATA   out  write data
//     APB_PRDATA   in   read data from the slave
//     APB_PREADY   in   slave ready
//     APB_PSLVERR  in   slave error, sampled only with PREADY high
// -----------------------------------------------------------------------------
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int unsigned PDATA_SIZE     = 32,
    parameter int unsigned PADDR_SIZE     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    APB_CLK,
    input  logic                    APB_RESET,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [PADDR_SIZE-1:0]   cmd_addr,
    input  logic [PDATA_SIZE-1:0]   cmd_wdata,
    input  logic [PDATA_SIZE/8-1:0] cmd_strb,

    output logic                    rsp_valid,
    output logic [PDATA_SIZE-1:0]   rsp_rdata,
    output logic                    rsp_error,
    output logic                    rsp_timeout,

    output logic                    APB_PSEL,
    output logic                    APB_PENABLE,
    output logic [PADDR_SIZE-1:0]   APB_PADDR,
    output logic                    APB_PWRITE,
    output logic [PDATA_SIZE/8-1:0] APB_PSTRB,
    output logic [PDATA_SIZE-1:0]   APB_PWDATA,
    input  logic [PDATA_SIZE-1:0]   APB_PRDATA,
    input  logic                    APB_PREADY,
    input  logic                    APB_PSLVERR
);

    localparam int unsigned STRB_W = PDATA_SIZE / 8;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    apb_state_e              state_q,       state_d;
    logic [PADDR_SIZE-1:0]   paddr_q,       paddr_d;
    logic                    pwrite_q,      pwrite_d;
    logic [STRB_W-1:0]       pstrb_q,       pstrb_d;
    logic [PDATA_SIZE-1:0]   pwdata_q,      pwdata_d;
    logic                    rsp_valid_q,   rsp_valid_d;
    logic [PDATA_SIZE-1:0]   rsp_rdata_q,   rsp_rdata_d;
    logic                    rsp_error_q,   rsp_error_d;
    logic                    rsp_timeout_q, rsp_timeout_d;

    logic                    wdog_clear;
    logic                    wdog_enable;
    logic                    wdog_expired;

    // -------------------------------------------------------------------------
    // Watchdog: restarted when a command is accepted, advanced on every
    // ACCESS cycle in which the slave is still waiting.
    // -------------------------------------------------------------------------
    apb_wdog_counter #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i     (APB_CLK),
        .rst_i     (APB_RESET),
        .clear_i   (wdog_clear),
        .enable_i  (wdog_enable),
        .expired_o (wdog_expired)
    );

    // Ready only in IDLE, and held low while reset is asserted so nothing is
    // handshaken on an edge that will be discarded anyway.
    assign cmd_ready = (state_q == IDLE) && !APB_RESET;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pstrb_d       = pstrb_q;
        pwdata_d      = pwdata_q;
        // Response fields are strobes: they fall back to zero every cycle
        // that is not a completion, which keeps error/timeout low whenever
        // rsp_valid is low.
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_error_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        wdog_clear    = 1'b0;
        wdog_enable   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    // The APB address/control/data registers are loaded here
                    // and left untouched until the next acceptance, which
                    // keeps them stable from SETUP through the last ACCESS.
                    paddr_d    = cmd_addr;
                    pwrite_d   = cmd_write;
                    pstrb_d    = cmd_write ? cmd_strb : '0;
                    pwdata_d   = cmd_wdata;
                    wdog_clear = 1'b1;
                    state_d    = SETUP;
                end
            end

            SETUP: begin
                state_d = ACCESS;
            end

            ACCESS: begin
                // An unknown PREADY fails this test and falls into the wait
                // branch, so X/Z behaves like a wait state.
                if (APB_PREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = APB_PSLVERR;
                    rsp_rdata_d = pwrite_q ? '0 : APB_PRDATA;
                    state_d     = IDLE;
                end else begin
                    wdog_enable = 1'b1;
                    if (wdog_expired) begin
                        rsp_valid_d   = 1'b1;
                        rsp_error_d   = 1'b1;
                        rsp_timeout_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge APB_CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (APB_RESET) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pstrb_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pstrb_q       <= pstrb_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // PSEL/PENABLE decode straight from the state register, so a reset in the
    // middle of a transfer drops both on the reset edge.
    assign APB_PSEL    = (state_q == SETUP) || (state_q == ACCESS);
    assign APB_PENABLE = (state_q == ACCESS);
    assign APB_PADDR   = paddr_q;
    assign APB_PWRITE  = pwrite_q;
    assign APB_PSTRB   = pstrb_q;
    assign APB_PWDATA  = pwdata_q;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule : apb_cmd_master

// File: tb/tb_apb_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_apb_cmd_master
//   Self-checking bench for apb_cmd_master. The bench plays the command
//   source and a behavioural APB slave (a 16-word register file with
//   programmable wait states and error injection). Expected bus activity and
//   responses are derived from transfer-level rules: a transfer occupies one
//   SETUP cycle, then one ACCESS cycle per wait state plus the completing one,
//   unless the slave keeps waiting for TIMEOUT ACCESS cycles.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_apb_cmd_master;
    import apb_pkg::*;

    localparam int TIMEOUT = 16;

    typedef struct {
        logic        write;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;   // ACCESS cycles with PREADY low before ready
        bit          err;     // slave flags PSLVERR on the completing cycle
        bit          hang;    // slave never asserts PREADY
    } cmd_t;

    logic        clk;
    logic        APB_RESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;
    logic        APB_PSEL;
    logic        APB_PENABLE;
    logic [3:0]  APB_PADDR;
    logic        APB_PWRITE;
    logic [3:0]  APB_PSTRB;
    logic [31:0] APB_PWDATA;
    logic [31:0] APB_PRDATA;
    logic        APB_PREADY;
    logic        APB_PSLVERR;

    // Slave register file, the reference for read data.
    logic [31:0] mem [16];

    int errors = 0;
    int checks = 0;

    apb_cmd_master #(
        .PDATA_SIZE     (32),
        .PADDR_SIZE     (4),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .APB_CLK     (clk),
        .APB_RESET   (APB_RESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .APB_PSEL    (APB_PSEL),
        .APB_PENABLE (APB_PENABLE),
        .APB_PADDR   (APB_PADDR),
        .APB_PWRITE  (APB_PWRITE),
        .APB_PSTRB   (APB_PSTRB),
        .APB_PWDATA  (APB_PWDATA),
        .APB_PRDATA  (APB_PRDATA),
        .APB_PREADY  (APB_PREADY),
        .APB_PSLVERR (APB_PSLVERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls outside the bounded loops.
    initial begin
        #300000;
        $display("FAIL global_time_limit: bench still running at %0t", $time);
        $fatal(1);
    end

    // ---------------------------------------------------------------- helpers
    function automatic cmd_t mk(input logic write, input logic [3:0] addr,
                                input logic [31:0] wdata, input logic [3:0] strb,
                                input int waits, input bit err, input bit hang);
        cmd_t c;
        c.write = write; c.addr = addr; c.wdata = wdata; c.strb = strb;
        c.waits = waits; c.err = err;   c.hang = hang;
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.write = 1'($urandom);
        c.addr  = 4'($urandom);
        c.wdata = $urandom;
        c.strb  = 4'($urandom);
        c.waits = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 17))
                                              : int'($urandom_range(0, 3));
        c.err   = ($urandom_range(0, 7) == 0);
        c.hang  = 1'b0;
        return c;
    endfunction

    task automatic drive_cmd(input cmd_t c);
        cmd_valid = 1'b1;
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        cmd_strb  = c.strb;
    endtask

    // Idle command port with junk on the payload, so any late re-latching
    // shows up on the bus.
    task automatic drive_idle();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 4'($urandom);
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
    endtask

    // Wait for the next falling edge, expect an idle requester, then present c.
    task automatic issue(input cmd_t c);
        @(negedge clk);
        checks++;
        if ({APB_PSEL, APB_PENABLE, cmd_ready, rsp_valid} !== 4'b0010) begin
            errors++;
            $display("FAIL idle_before_cmd: sel/en/ready/rsp got %b want 0010",
                     {APB_PSEL, APB_PENABLE, cmd_ready, rsp_valid});
        end
        drive_cmd(c);
    endtask

    // Follow an accepted command from its SETUP cycle through its response
    // cycle, playing the slave. With hold set, nxt is presented (and held)
    // from the SETUP cycle on, so it is accepted in the response cycle.
    task automatic finish_txn(input cmd_t c, input bit hold, input cmd_t nxt);
        logic [40:0] bus_exp;
        logic [31:0] prd;
        logic [31:0] rdata_exp;
        bit          done;
        bit          timed_out;
        int          i;
        bus_exp   = {c.addr, c.write, (c.write ? c.strb : 4'b0000), c.wdata};
        prd       = '0;
        done      = 1'b0;
        timed_out = 1'b0;
        i         = 0;

        @(negedge clk);
        checks++;
        if ({APB_PSEL, APB_PENABLE, cmd_ready, rsp_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL setup_phase: sel/en/ready/rsp got %b want 1000",
                     {APB_PSEL, APB_PENABLE, cmd_ready, rsp_valid});
        end
        checks++;
        if ({APB_PADDR, APB_PWRITE, APB_PSTRB, APB_PWDATA} !== bus_exp) begin
            errors++;
            $display("FAIL setup_bus: addr/wr/strb/wdata got %h want %h",
                     {APB_PADDR, APB_PWRITE, APB_PSTRB, APB_PWDATA}, bus_exp);
        end
        if (hold) drive_cmd(nxt);
        else      drive_idle();

        while (!done && i < 64) begin
            @(negedge clk);
            checks++;
            if ({APB_PSEL, APB_PENABLE, cmd_ready, rsp_valid} !== 4'b1100) begin
                errors++;
                $display("FAIL access_phase[%0d]: sel/en/ready/rsp got %b want 1100",
                         i, {APB_PSEL, APB_PENABLE, cmd_ready, rsp_valid});
            end
            checks++;
            if ({APB_PADDR, APB_PWRITE, APB_PSTRB, APB_PWDATA} !== bus_exp) begin
                errors++;
                $display("FAIL access_bus_stable[%0d]: got %h want %h", i,
                         {APB_PADDR, APB_PWRITE, APB_PSTRB, APB_PWDATA}, bus_exp);
            end
            if (!c.hang && i == c.waits) begin
                prd         = (c.write || c.err) ? $urandom : mem[c.addr];
                APB_PREADY  = 1'b1;
                APB_PSLVERR = c.err;
                APB_PRDATA  = prd;
                done        = 1'b1;
            end else begin
                // Junk on PSLVERR/PRDATA during waits must be ignored.
                APB_PREADY  = 1'b0;
                APB_PSLVERR = 1'($urandom);
                APB_PRDATA  = $urandom;
                if (i == TIMEOUT - 1) begin
                    timed_out = 1'b1;
                    done      = 1'b1;
                end
            end
            i++;
        end

        @(negedge clk);
        APB_PREADY  = 1'b0;
        APB_PSLVERR = 1'b0;
        APB_PRDATA  = $urandom;
        rdata_exp   = (timed_out || c.write) ? 32'h0 : prd;
        checks++;
        if ({rsp_valid, rsp_error, rsp_timeout} !== {1'b1, timed_out | c.err, timed_out}) begin
            errors++;
            $display("FAIL rsp_status: valid/err/tmo got %b want %b",
                     {rsp_valid, rsp_error, rsp_timeout}, {1'b1, timed_out | c.err, timed_out});
        end
        checks++;
        if (rsp_rdata !== rdata_exp) begin
            errors++;
            $display("FAIL rsp_rdata: got %h want %h", rsp_rdata, rdata_exp);
        end
        checks++;
        if ({APB_PSEL, APB_PENABLE, cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL rsp_cycle_bus: sel/en/ready got %b want 001",
                     {APB_PSEL, APB_PENABLE, cmd_ready});
        end
        if (c.write && !c.err && !timed_out) begin
            for (int b = 0; b < 4; b++)
                if (c.strb[b]) mem[c.addr][8*b +: 8] = c.wdata[8*b +: 8];
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        APB_RESET = 1'b1;
        drive_cmd(mk(1'b1, 4'h7, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 1'b0));
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready);
        end
        checks++;
        if ({APB_PSEL, APB_PENABLE, APB_PADDR, APB_PWRITE, APB_PSTRB, APB_PWDATA,
             rsp_valid, rsp_error, rsp_timeout, rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: sel=%b en=%b addr=%h wr=%b strb=%h wdata=%h rsp=%b%b%b rdata=%h want all 0",
                     APB_PSEL, APB_PENABLE, APB_PADDR, APB_PWRITE, APB_PSTRB, APB_PWDATA,
                     rsp_valid, rsp_error, rsp_timeout, rsp_rdata);
        end
        APB_RESET = 1'b0;
        drive_idle();
    endtask

    task automatic test_gpio_write();
        cmd_t w, r;
        w = mk(1'b1, 4'(GPIO_DIRECTION), 32'h0000_00FF, 4'b1111, 0, 1'b0, 1'b0);
        issue(w);
        finish_txn(w, 1'b0, w);
        r = mk(1'b0, 4'(GPIO_DIRECTION), 32'h1234_5678, 4'b1111, 0, 1'b0, 1'b0);
        issue(r);
        finish_txn(r, 1'b0, r);
        checks++;
        if (mem[GPIO_DIRECTION] !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL gpio_dir_reg: got %h want 000000ff", mem[GPIO_DIRECTION]);
        end
    endtask

    task automatic test_wait_read();
        cmd_t r;
        mem[3] = 32'hA5A5_0001;
        r = mk(1'b0, 4'd3, 32'hFFFF_FFFF, 4'b1111, 2, 1'b0, 1'b0);
        issue(r);
        finish_txn(r, 1'b0, r);
    endtask

    task automatic test_slverr();
        cmd_t w, r;
        w = mk(1'b1, 4'(GPIO_MODE), 32'h0BAD_0BAD, 4'b1111, 0, 1'b1, 1'b0);
        issue(w);
        finish_txn(w, 1'b0, w);
        // An error read still hands back whatever PRDATA carried.
        r = mk(1'b0, 4'd9, 32'h0, 4'b0000, 1, 1'b1, 1'b0);
        issue(r);
        finish_txn(r, 1'b0, r);
    endtask

    task automatic test_timeout();
        cmd_t h, b15, b16;
        h = mk(1'b0, 4'd5, 32'h0, 4'b0000, 0, 1'b0, 1'b1);
        issue(h);
        finish_txn(h, 1'b0, h);
        // Ready on the 16th ACCESS cycle is a normal completion.
        b15 = mk(1'b0, 4'd6, 32'h0, 4'b0000, TIMEOUT - 1, 1'b0, 1'b0);
        issue(b15);
        finish_txn(b15, 1'b0, b15);
        // Ready would come one cycle too late: watchdog wins.
        b16 = mk(1'b1, 4'd7, 32'h7777_7777, 4'b1111, TIMEOUT, 1'b0, 1'b0);
        issue(b16);
        finish_txn(b16, 1'b0, b16);
    endtask

    task automatic test_reset_mid();
        cmd_t r, w;
        r = mk(1'b0, 4'd2, 32'h0, 4'b0000, 0, 1'b0, 1'b0);
        issue(r);
        @(negedge clk);
        checks++;
        if ({APB_PSEL, APB_PENABLE} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_setup: sel/en got %b want 10", {APB_PSEL, APB_PENABLE});
        end
        drive_idle();
        @(negedge clk);
        checks++;
        if ({APB_PSEL, APB_PENABLE} !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_access: sel/en got %b want 11", {APB_PSEL, APB_PENABLE});
        end
        APB_PREADY = 1'b0;
        APB_RESET  = 1'b1;
        @(negedge clk);
        checks++;
        if ({APB_PSEL, APB_PENABLE, cmd_ready, rsp_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_drop: sel/en/ready/rsp got %b want 0000",
                     {APB_PSEL, APB_PENABLE, cmd_ready, rsp_valid});
        end
        APB_RESET = 1'b0;
        @(negedge clk);
        checks++;
        if ({APB_PSEL, APB_PENABLE, cmd_ready, rsp_valid} !== 4'b0010) begin
            errors++;
            $display("FAIL rstmid_after: sel/en/ready/rsp got %b want 0010",
                     {APB_PSEL, APB_PENABLE, cmd_ready, rsp_valid});
        end
        w = mk(1'b1, 4'(GPIO_OUTPUT), 32'hC0FF_EE00, 4'b0101, 0, 1'b0, 1'b0);
        issue(w);
        finish_txn(w, 1'b0, w);
    endtask

    task automatic test_back_to_back();
        cmd_t a, b;
        a = mk(1'b1, 4'(GPIO_MODE),   32'h1111_2222, 4'b1111, 0, 1'b0, 1'b0);
        b = mk(1'b1, 4'(GPIO_OUTPUT), 32'h3333_4444, 4'b0011, 1, 1'b0, 1'b0);
        issue(a);
        finish_txn(a, 1'b1, b);   // b accepted in a's response cycle
        finish_txn(b, 1'b0, b);
    endtask

    task automatic test_random();
        cmd_t c, nxt;
        bit   hold;
        c = rand_cmd();
        issue(c);
        for (int n = 0; n < 40; n++) begin
            nxt  = rand_cmd();
            hold = 1'($urandom);
            finish_txn(c, hold, nxt);
            if (!hold) issue(nxt);
            c = nxt;
        end
        finish_txn(c, 1'b0, c);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mem[k] = $urandom;
        APB_RESET   = 1'b1;
        APB_PREADY  = 1'b0;
        APB_PSLVERR = 1'b0;
        APB_PRDATA  = '0;
        drive_idle();

        test_reset();
        test_gpio_write();
        test_wait_read();
        test_slverr();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();

        @(negedge clk);
        checks++;
        if ({APB_PSEL, rsp_valid, cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL final_idle: sel/rsp/ready got %b want 001",
                     {APB_PSEL, rsp_valid, cmd_ready});
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_apb_cmd_master
